hilo_muldiv_unit: RTL and testbench

- Iterative multiply/divide sequencer that owns the HI/LO registers for the multicycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU at one iteration per cycle. Also services MTHI and MTLO.
- Drives busy_o to the top-level stall logic, so MFHI/MFLO and further mul/div instructions hold in EXEC2 until the result is committed.
- Sits beside the ALU and is started by the control block in EXEC2.

---
 rtl/hilo_muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the multicycle core: iterative shift-add multiply and restoring
// divide at one bit per cycle, plus direct MTHI/MTLO writes.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  // MUL: {accumulator, remaining multiplier bits}; DIV: low half shifts dividend out, quotient in
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic [WIDTH-1:0]   a_raw_reg;
  logic               is_div_reg;
  logic               neg_lo_reg;
  logic               neg_hi_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               start_mul, start_div, op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign start_mul = start_i && (op_i == OP_MULT || op_i == OP_MULTU);
  assign start_div = start_i && (op_i == OP_DIV  || op_i == OP_DIVU);
  assign op_signed = ~op_i[0];
  assign a_mag     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  assign mul_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_step = {mul_sum, prod_reg[WIDTH-1:1]};

  // Bit WIDTH of the difference is the borrow: set means the trial subtract failed.
  assign rem_shift = {rem_reg, prod_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opb_reg};
  assign div_ge    = ~rem_diff[WIDTH];

  always_comb begin
    prod_fix = neg_lo_reg ? -prod_reg : prod_reg;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (opb_reg == '0) begin
        fix_hi = a_raw_reg;
        fix_lo = '1;
      end else begin
        fix_hi = neg_hi_reg ? -rem_reg : rem_reg;
        fix_lo = neg_lo_reg ? -prod_reg[WIDTH-1:0] : prod_reg[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_mul)      state_next = MUL;
        else if (start_div) state_next = DIV;
      end
      MUL, DIV: if (cnt_reg == LAST_CNT) state_next = FIX;
      FIX:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      prod_reg   <= '0;
      rem_reg    <= '0;
      opb_reg    <= '0;
      a_raw_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (start_mul || start_div) begin
            prod_reg   <= {{WIDTH{1'b0}}, a_mag};
            rem_reg    <= '0;
            opb_reg    <= b_mag;
            a_raw_reg  <= a_i;
            is_div_reg <= start_div;
            neg_lo_reg <= op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_hi_reg <= op_signed && a_i[WIDTH-1];
          end else if (start_i && op_i == OP_MTHI) begin
            hi_reg <= a_i;
          end else if (start_i && op_i == OP_MTLO) begin
            lo_reg <= a_i;
          end
        end
        MUL: begin
          prod_reg <= mul_step;
          cnt_reg  <= cnt_reg + 1'b1;
        end
        DIV: begin
          prod_reg[WIDTH-1:0] <= {prod_reg[WIDTH-2:0], div_ge};
          rem_reg             <= div_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          cnt_reg             <= cnt_reg + 1'b1;
        end
        FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_reg != IDLE);
  assign done_o = done_reg;
  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: table of mul/div vectors plus hand-written
// sequences for busy-time restart, back-to-back issue, MTHI/MTLO and mid-op reset.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_applied = 0;
  int n_miss    = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [31:0] phi, input logic [31:0] plo,
                        input int inj_cyc, input string tag);
    int   cycles;
    logic hold_bad;
    logic done_bad;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0;
    cycles = 0; hold_bad = 1'b0; done_bad = 1'b0;
    while (busy_o === 1'b1 && cycles < 100) begin
      if (hi_o !== phi || lo_o !== plo) hold_bad = 1'b1;
      if (done_o !== 1'b0) done_bad = 1'b1;
      if (cycles == inj_cyc) begin
        start_i = 1'b1; op_i = 3'd3; a_i = 32'd9; b_i = 32'd3;
      end else begin
        start_i = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, " busy_cycles"}, 64'(cycles), 64'd33);
    check({tag, " hilo_hold"}, {63'd0, hold_bad}, 64'd0);
    check({tag, " done_early"}, {63'd0, done_bad}, 64'd0);
    check({tag, " done_pulse"}, {63'd0, done_o}, 64'd1);
    check({tag, " hi"}, {32'd0, hi_o}, {32'd0, ehi});
    check({tag, " lo"}, {32'd0, lo_o}, {32'd0, elo});
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", tag, op, a, b, hi_o, lo_o, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] phi, plo;
    logic        seen_busy, seen_done, hold_bad;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3]  = '{3'd0, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
    vecs[4]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[6]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[9]  = '{3'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[10] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    reset = 1'b1; start_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {63'd0, busy_o}, 64'd0);
    check("reset done", {63'd0, done_o}, 64'd0);
    check("reset hi", {32'd0, hi_o}, 64'd0);
    check("reset lo", {32'd0, lo_o}, 64'd0);
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy_o, done_o, hi_o, lo_o);

    phi = '0; plo = '0;
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, phi, plo, -1,
             $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d done_fall", i), {63'd0, done_o}, 64'd0);
      phi = vecs[i].hi; plo = vecs[i].lo;
    end

    // A DIVU request arriving mid-MULTU must be dropped entirely.
    run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, phi, plo, 10, "busy_restart");
    @(negedge clk);
    check("busy_restart done_fall", {63'd0, done_o}, 64'd0);

    // Second op issued in the done cycle of the first.
    run_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 32'd0, 32'd6, -1, "chain_a");
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'd1, 32'd3, -1, "chain_b");
    @(negedge clk);
    check("chain_b done_fall", {63'd0, done_o}, 64'd0);

    start_i = 1'b1; op_i = 3'd4; a_i = 32'hAAAA0000;
    @(negedge clk);
    seen_busy = busy_o; seen_done = done_o;
    op_i = 3'd5; a_i = 32'h00005555;
    @(negedge clk);
    seen_busy |= busy_o; seen_done |= done_o;
    start_i = 1'b0;
    @(negedge clk);
    seen_busy |= busy_o; seen_done |= done_o;
    check("mthi hi", {32'd0, hi_o}, 64'h00000000AAAA0000);
    check("mtlo lo", {32'd0, lo_o}, 64'h0000000000005555);
    check("mthi_mtlo busy", {63'd0, seen_busy}, 64'd0);
    check("mthi_mtlo done", {63'd0, seen_done}, 64'd0);
    $display("mthi/mtlo: hi=%h lo=%h busy_seen=%b", hi_o, lo_o, seen_busy);

    start_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    hold_bad = 1'b0;
    seen_busy = busy_o;
    repeat (14) begin
      if (hi_o !== 32'hAAAA0000 || lo_o !== 32'h00005555) hold_bad = 1'b1;
      @(negedge clk);
    end
    check("abort busy_before", {63'd0, seen_busy}, 64'd1);
    check("abort hilo_hold", {63'd0, hold_bad}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {63'd0, busy_o}, 64'd0);
    check("abort hi", {32'd0, hi_o}, 64'd0);
    check("abort lo", {32'd0, lo_o}, 64'd0);
    check("abort done", {63'd0, done_o}, 64'd0);
    seen_busy = 1'b0; seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_busy |= busy_o; seen_done |= done_o;
    end
    check("abort no_done", {63'd0, seen_done}, 64'd0);
    check("abort no_busy", {63'd0, seen_busy}, 64'd0);
    $display("abort: busy=%b hi=%h lo=%h done_seen=%b", busy_o, hi_o, lo_o, seen_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
